// File: rtl/gshare_predictor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gshare_predictor_pkg
//  Description : Shared types and helpers for the gshare direction predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
package gshare_predictor_pkg;

    // Table initialisation sweep versus normal operation.
    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_READY = 1'b1
    } sweep_state_e;

    // Saturating increment/decrement of a WIDTH-bit counter.
    function automatic logic [31:0] sat_step(input logic [31:0] prev,
                                             input logic        taken,
                                             input int unsigned width);
        logic [31:0] max_v;
        max_v = (32'd1 << width) - 32'd1;
        if (taken) begin
            sat_step = (prev >= max_v) ? max_v : prev + 32'd1;
        end else begin
            sat_step = (prev == 32'd0) ? 32'd0 : prev - 32'd1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/gshare_predictor_update_queue.sv
`default_nettype none
// ============================================================================
//  Module      : gshare_update_queue
//  Description : Multi-push, single-pop circular FIFO with wrap-around
//                pointers. Pushes are accepted in ascending lane order until
//                the queue is full (after a same-cycle pop); the rest drop.
//  Revision    : 1.0 - initial release
// ============================================================================
module gshare_update_queue #(
    parameter int DEPTH    = 8,
    parameter int PUSH_NUM = 2,
    parameter int DATA_W   = 13,
    parameter int DROP_W   = $clog2(PUSH_NUM + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [PUSH_NUM-1:0]                push_valid_i,
    input  logic [PUSH_NUM-1:0][DATA_W-1:0]    push_data_i,
    input  logic                               pop_i,
    output logic [DATA_W-1:0]                  head_o,
    output logic                               empty_o,
    output logic [DROP_W-1:0]                  drop_num_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0]                  mem_q [DEPTH];
    logic [PTR_W-1:0]                   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]                   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]                   count_q, count_d;
    logic                               w_pop_en;
    logic [PUSH_NUM-1:0]                w_push_en;
    logic [PUSH_NUM-1:0][PTR_W-1:0]     w_push_ptr;

    assign w_pop_en   = pop_i && (count_q != '0);
    assign head_o     = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);

    // Allocate consecutive slots to valid lanes while space remains.
    always_comb begin
        logic [CNT_W-1:0] free;
        logic [CNT_W-1:0] pushed;
        logic [PTR_W-1:0] wr;
        free       = CNT_W'(DEPTH) - count_q + CNT_W'(w_pop_en);
        pushed     = '0;
        wr         = wr_ptr_q;
        w_push_en  = '0;
        w_push_ptr = '0;
        drop_num_o = '0;
        for (int i = 0; i < PUSH_NUM; i++) begin
            w_push_ptr[i] = wr;
            if (push_valid_i[i]) begin
                if (free != '0) begin
                    w_push_en[i] = 1'b1;
                    wr           = wr + PTR_W'(1);
                    free         = free - CNT_W'(1);
                    pushed       = pushed + CNT_W'(1);
                end else begin
                    drop_num_o = drop_num_o + DROP_W'(1);
                end
            end
        end
        wr_ptr_d = wr;
        rd_ptr_d = rd_ptr_q + PTR_W'(w_pop_en);
        count_d  = count_q - CNT_W'(w_pop_en) + pushed;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write for every accepted lane (slots are distinct).
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_NUM; i++) begin
            if (w_push_en[i]) begin
                mem_q[w_push_ptr[i]] <= push_data_i[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : gshare_predictor
//  Description : gshare direction predictor. Counter table indexed by
//                PC XOR speculative global history, READ_NUM lanes per
//                cycle, queued multi-lane resolution updates, history
//                recovery on misprediction, reset-time table sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int ENTRY_NUM   = 2048,
    parameter int COUNTER_W   = 2,
    parameter int HISTORY_W   = 10,
    parameter int READ_NUM    = 2,
    parameter int UPDATE_NUM  = 2,
    parameter int QUEUE_DEPTH = 8,
    parameter int PC_W        = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic                                 ready_o,
    input  logic                                 pred_req_i,
    input  logic [PC_W-1:0]                      pred_pc_i,
    input  logic [READ_NUM-1:0]                  pred_btb_hit_i,
    output logic [READ_NUM-1:0]                  pred_taken_o,
    output logic [READ_NUM-1:0][COUNTER_W-1:0]   pred_counter_o,
    output logic [HISTORY_W-1:0]                 pred_history_o,
    input  logic [UPDATE_NUM-1:0]                upd_valid_i,
    input  logic [UPDATE_NUM-1:0][PC_W-1:0]      upd_pc_i,
    input  logic [UPDATE_NUM-1:0][HISTORY_W-1:0] upd_history_i,
    input  logic [UPDATE_NUM-1:0][COUNTER_W-1:0] upd_counter_i,
    input  logic [UPDATE_NUM-1:0]                upd_taken_i,
    input  logic [UPDATE_NUM-1:0]                upd_mispred_i,
    output logic [15:0]                          drop_count_o
);

    localparam int INDEX_W = $clog2(ENTRY_NUM);
    localparam int QE_W    = INDEX_W + COUNTER_W;
    localparam int DROP_W  = $clog2(UPDATE_NUM + 1);
    localparam logic [COUNTER_W-1:0] WEAK_TAKEN = COUNTER_W'(1) << (COUNTER_W - 1);

    logic [COUNTER_W-1:0]                  table_q [ENTRY_NUM];
    sweep_state_e                          state_q, state_d;
    logic [INDEX_W-1:0]                    sweep_idx_q, sweep_idx_d;
    logic [HISTORY_W-1:0]                  ghr_q, ghr_d;
    logic [READ_NUM-1:0]                   pred_taken_q;
    logic [READ_NUM-1:0][COUNTER_W-1:0]    pred_counter_q;
    logic [HISTORY_W-1:0]                  pred_history_q;
    logic [15:0]                           drop_count_q, drop_count_d;

    logic                                  w_ready;
    logic [READ_NUM-1:0][INDEX_W-1:0]      w_rd_idx;
    logic [READ_NUM-1:0][COUNTER_W-1:0]    w_rd_ctr;
    logic [READ_NUM-1:0]                   w_lane_taken;
    logic [HISTORY_W-1:0]                  w_spec_ghr;
    logic [UPDATE_NUM-1:0]                 w_upd_eff;
    logic                                  w_mis_found;
    logic [HISTORY_W-1:0]                  w_rec_ghr;
    logic [UPDATE_NUM-1:0][QE_W-1:0]       w_qe;
    logic [UPDATE_NUM-1:0]                 w_push_valid;
    logic                                  w_byp_en;
    logic [QE_W-1:0]                       w_byp_data;
    logic                                  w_q_empty;
    logic                                  w_pop;
    logic [QE_W-1:0]                       w_q_head;
    logic [DROP_W-1:0]                     w_drop_num;
    logic                                  w_wr_en;
    logic [INDEX_W-1:0]                    w_wr_idx;
    logic [COUNTER_W-1:0]                  w_wr_data;
    logic [16:0]                           w_drop_sum;
    logic                                  w_unused_pred_pc;

    assign w_ready          = (state_q == ST_READY);
    assign ready_o          = w_ready;
    assign pred_taken_o     = pred_taken_q;
    assign pred_counter_o   = pred_counter_q;
    assign pred_history_o   = pred_history_q;
    assign drop_count_o     = drop_count_q;
    assign w_unused_pred_pc = ^{pred_pc_i[PC_W-1:INDEX_W+2], pred_pc_i[1:0]};

    // Lane i sits at pred_pc + 4i; only the index bits matter, so the
    // lane offset is added directly on the word-address slice.
    for (genvar gi = 0; gi < READ_NUM; gi++) begin : g_rd_lane
        assign w_rd_idx[gi] = (pred_pc_i[INDEX_W+1:2] + INDEX_W'(gi)) ^ INDEX_W'(ghr_q);
        assign w_rd_ctr[gi] = table_q[w_rd_idx[gi]];
    end

    // Per-lane table index and next counter value of each resolution lane.
    for (genvar gu = 0; gu < UPDATE_NUM; gu++) begin : g_upd_lane
        logic [INDEX_W-1:0]   w_idx;
        logic [COUNTER_W-1:0] w_ctr;
        logic                 w_unused_upd_pc;
        assign w_idx = upd_pc_i[gu][INDEX_W+1:2] ^ INDEX_W'(upd_history_i[gu]);
        assign w_ctr = COUNTER_W'(sat_step(32'(upd_counter_i[gu]), upd_taken_i[gu], COUNTER_W));
        assign w_qe[gu] = {w_idx, w_ctr};
        assign w_unused_upd_pc = ^{upd_pc_i[gu][PC_W-1:INDEX_W+2], upd_pc_i[gu][1:0]};
    end

    // First-taken masking and the speculative history shift it implies.
    always_comb begin
        logic found;
        found        = 1'b0;
        w_lane_taken = '0;
        w_spec_ghr   = ghr_q;
        for (int i = 0; i < READ_NUM; i++) begin
            if (pred_btb_hit_i[i] && !found) begin
                w_lane_taken[i] = w_rd_ctr[i][COUNTER_W-1];
                w_spec_ghr      = {w_spec_ghr[HISTORY_W-2:0], w_rd_ctr[i][COUNTER_W-1]};
                found           = w_rd_ctr[i][COUNTER_W-1];
            end
        end
    end

    // Lanes up to and including the lowest mispredict are live; that lane
    // also supplies the recovered history.
    always_comb begin
        w_upd_eff   = '0;
        w_mis_found = 1'b0;
        w_rec_ghr   = ghr_q;
        for (int i = 0; i < UPDATE_NUM; i++) begin
            if (w_ready && upd_valid_i[i] && !w_mis_found) begin
                w_upd_eff[i] = 1'b1;
                if (upd_mispred_i[i]) begin
                    w_mis_found = 1'b1;
                    w_rec_ghr   = {upd_history_i[i][HISTORY_W-2:0], upd_taken_i[i]};
                end
            end
        end
    end

    // With an empty queue the lowest live lane bypasses to the write port.
    always_comb begin
        logic port_busy;
        port_busy    = !w_q_empty;
        w_push_valid = '0;
        w_byp_en     = 1'b0;
        w_byp_data   = '0;
        for (int i = 0; i < UPDATE_NUM; i++) begin
            if (w_upd_eff[i]) begin
                if (!port_busy) begin
                    w_byp_en   = 1'b1;
                    w_byp_data = w_qe[i];
                    port_busy  = 1'b1;
                end else begin
                    w_push_valid[i] = 1'b1;
                end
            end
        end
    end

    assign w_pop = w_ready && !w_q_empty;

    gshare_update_queue #(
        .DEPTH    (QUEUE_DEPTH),
        .PUSH_NUM (UPDATE_NUM),
        .DATA_W   (QE_W),
        .DROP_W   (DROP_W)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (w_push_valid),
        .push_data_i  (w_qe),
        .pop_i        (w_pop),
        .head_o       (w_q_head),
        .empty_o      (w_q_empty),
        .drop_num_o   (w_drop_num)
    );

    // Single write port: sweep, then queue head, then bypass lane.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = sweep_idx_q;
        w_wr_data = WEAK_TAKEN;
        if (state_q == ST_SWEEP) begin
            w_wr_en = !rst;
        end else if (w_pop) begin
            w_wr_en                = 1'b1;
            {w_wr_idx, w_wr_data}  = w_q_head;
        end else if (w_byp_en) begin
            w_wr_en                = 1'b1;
            {w_wr_idx, w_wr_data}  = w_byp_data;
        end
    end

    // Counter table storage; a same-cycle read sees the pre-write value.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            table_q[w_wr_idx] <= w_wr_data;
        end
    end

    // Sweep sequencing: one entry per cycle, ready after the last one.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        if (state_q == ST_SWEEP) begin
            sweep_idx_d = sweep_idx_q + INDEX_W'(1);
            if (sweep_idx_q == INDEX_W'(ENTRY_NUM - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    // History next state: recovery wins over the speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (w_ready && pred_req_i) begin
            ghr_d = w_spec_ghr;
        end
        if (w_mis_found) begin
            ghr_d = w_rec_ghr;
        end
    end

    assign w_drop_sum   = {1'b0, drop_count_q} + 17'(w_drop_num);
    assign drop_count_d = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    // Control state, history, drop counter and registered prediction outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_SWEEP;
            sweep_idx_q    <= '0;
            ghr_q          <= '0;
            drop_count_q   <= '0;
            pred_taken_q   <= '0;
            pred_counter_q <= '0;
            pred_history_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_idx_q  <= sweep_idx_d;
            ghr_q        <= ghr_d;
            drop_count_q <= drop_count_d;
            if (w_ready && pred_req_i) begin
                pred_taken_q   <= w_lane_taken;
                pred_counter_q <= w_rd_ctr;
                pred_history_q <= ghr_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gshare_predictor
//  Description : Self-checking bench for gshare_predictor (16 entries,
//                4-bit history, 2-deep update queue).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_predictor;

    localparam int ENTRIES = 16;
    localparam int HW      = 4;
    localparam int QD      = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             ready_o;
    logic             pred_req;
    logic [31:0]      pred_pc;
    logic [1:0]       pred_btb_hit;
    logic [1:0]       pred_taken_o;
    logic [1:0][1:0]  pred_counter_o;
    logic [HW-1:0]    pred_history_o;
    logic [1:0]       upd_valid;
    logic [1:0][31:0] upd_pc;
    logic [1:0][HW-1:0] upd_history;
    logic [1:0][1:0]  upd_counter;
    logic [1:0]       upd_taken;
    logic [1:0]       upd_mispred;
    logic [15:0]      drop_count_o;

    gshare_predictor #(
        .ENTRY_NUM(ENTRIES), .COUNTER_W(2), .HISTORY_W(HW), .READ_NUM(2),
        .UPDATE_NUM(2), .QUEUE_DEPTH(QD), .PC_W(32)
    ) dut (
        .clk(clk), .rst(rst), .ready_o(ready_o),
        .pred_req_i(pred_req), .pred_pc_i(pred_pc), .pred_btb_hit_i(pred_btb_hit),
        .pred_taken_o(pred_taken_o), .pred_counter_o(pred_counter_o),
        .pred_history_o(pred_history_o),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_history_i(upd_history),
        .upd_counter_i(upd_counter), .upd_taken_i(upd_taken),
        .upd_mispred_i(upd_mispred), .drop_count_o(drop_count_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int idx; int val; } qe_t;
    int   m_tab [ENTRIES];
    qe_t  m_q [$];
    int   m_ghr   = 0;
    int   m_drop  = 0;
    int   m_sweep = 0;
    bit   m_ready = 0;
    logic [1:0]    e_taken = '0;
    logic [3:0]    e_ctr   = '0;
    logic [HW-1:0] e_hist  = '0;

    always @(posedge clk) begin
        int  new_ghr, mis, idx, c, val, drops, wr_idx, wr_val;
        bit  stop, t, wr;
        qe_t e;
        if (rst) begin
            m_ghr = 0; m_q.delete(); m_drop = 0; m_ready = 0; m_sweep = 0;
            e_taken = '0; e_ctr = '0; e_hist = '0;
        end else if (!m_ready) begin
            m_tab[m_sweep] = 2;
            m_sweep++;
            if (m_sweep == ENTRIES) m_ready = 1;
        end else begin
            new_ghr = m_ghr; wr = 0; drops = 0; wr_idx = 0; wr_val = 0;
            if (pred_req) begin
                e_hist = HW'(m_ghr);
                stop = 0;
                for (int i = 0; i < 2; i++) begin
                    idx = (int'((pred_pc + 32'(4 * i)) >> 2) ^ m_ghr) % ENTRIES;
                    c = m_tab[idx];
                    t = (c >= 2) && pred_btb_hit[i] && !stop;
                    e_ctr[i*2 +: 2] = 2'(c);
                    e_taken[i] = t;
                    if (pred_btb_hit[i] && !stop) new_ghr = ((new_ghr << 1) | int'(t)) % ENTRIES;
                    if (t) stop = 1;
                end
            end
            mis = -1;
            for (int i = 0; i < 2; i++)
                if (upd_valid[i] && upd_mispred[i] && mis < 0) mis = i;
            if (m_q.size() > 0) begin
                e = m_q.pop_front();
                wr = 1; wr_idx = e.idx; wr_val = e.val;
            end
            for (int i = 0; i < 2; i++) begin
                if (upd_valid[i] && (mis < 0 || i <= mis)) begin
                    e.idx = (int'(upd_pc[i] >> 2) ^ int'(upd_history[i])) % ENTRIES;
                    c = int'(upd_counter[i]);
                    val = upd_taken[i] ? ((c + 1 > 3) ? 3 : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
                    e.val = val;
                    if (!wr) begin
                        wr = 1; wr_idx = e.idx; wr_val = e.val;
                    end else if (m_q.size() < QD) begin
                        m_q.push_back(e);
                    end else begin
                        drops++;
                    end
                end
            end
            if (mis >= 0) new_ghr = ((int'(upd_history[mis]) << 1) | int'(upd_taken[mis])) % ENTRIES;
            m_ghr = new_ghr;
            if (wr) m_tab[wr_idx] = wr_val;
            m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("ready",    32'(ready_o),        32'(m_ready));
        check("taken",    32'(pred_taken_o),   32'(e_taken));
        check("counter",  32'(pred_counter_o), 32'(e_ctr));
        check("history",  32'(pred_history_o), 32'(e_hist));
        check("drop",     32'(drop_count_o),   32'(m_drop));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_upd(input int lane, input logic [31:0] pc, input logic [HW-1:0] h,
                           input logic [1:0] c, input logic t, input logic m);
        upd_valid[lane]   = 1'b1;
        upd_pc[lane]      = pc;
        upd_history[lane] = h;
        upd_counter[lane] = c;
        upd_taken[lane]   = t;
        upd_mispred[lane] = m;
    endtask

    task automatic clear_upd();
        upd_valid   = '0;
        upd_mispred = '0;
    endtask

    initial begin
        int rise_at;
        rst = 1'b1; pred_req = 1'b0; pred_pc = '0; pred_btb_hit = '0;
        upd_valid = '0; upd_pc = '0; upd_history = '0; upd_counter = '0;
        upd_taken = '0; upd_mispred = '0;
        repeat (3) tick();
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_taken", 32'(pred_taken_o), 32'd0);
        check("rst_counter", 32'(pred_counter_o), 32'd0);
        check("rst_history", 32'(pred_history_o), 32'd0);
        check("rst_drop", 32'(drop_count_o), 32'd0);

        // Sweep interrupted at cycle 7, then a full sweep with requests pending.
        rst = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; pred_req = 1'b1; pred_btb_hit = 2'b11; pred_pc = '0;
        rise_at = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ready_o === 1'b1) begin
                rise_at = k;
                break;
            end
        end
        check("ready_rise_cycle", 32'(rise_at), 32'd16);
        pred_req = 1'b0;
        check("sweep_ghr_hold", 32'(pred_history_o), 32'd0);

        // Every index holds weakly taken after the sweep.
        for (int j = 0; j < 8; j++) begin
            pred_req = 1'b1; pred_btb_hit = 2'b00; pred_pc = 32'(j * 8);
            tick();
            check("sweep_value", 32'(pred_counter_o), 32'hA);
        end
        pred_req = 1'b0;

        // Raise idx0/idx1 to 3 (bypass + one queued), then saturation cases.
        set_upd(0, 32'h0, 4'h0, 2'd2, 1'b1, 1'b0);
        set_upd(1, 32'h4, 4'h0, 2'd2, 1'b1, 1'b0);
        tick(); clear_upd(); tick();
        for (int j = 0; j < 3; j++) begin
            set_upd(0, 32'h0, 4'h0, 2'd3, 1'b1, 1'b0); tick(); clear_upd();
        end
        for (int j = 0; j < 3; j++) begin
            set_upd(0, 32'h8, 4'h0, 2'd0, 1'b0, 1'b0); tick(); clear_upd();
        end
        set_upd(0, 32'hC, 4'h0, 2'd1, 1'b1, 1'b0); tick(); clear_upd();
        pred_req = 1'b1; pred_btb_hit = 2'b00; pred_pc = 32'h8;
        tick();
        check("sat_low_and_inc", 32'(pred_counter_o), 32'h8);
        pred_pc = 32'h0;
        tick();
        check("sat_high", 32'(pred_counter_o), 32'hF);

        // First-taken masking: both lanes strongly taken, only lane0 reported.
        pred_btb_hit = 2'b11;
        tick();
        check("first_taken_mask", 32'(pred_taken_o), 32'h1);
        check("first_taken_hist", 32'(pred_history_o), 32'h0);
        pred_btb_hit = 2'b00;
        tick();
        check("single_shift", 32'(pred_history_o), 32'h1);

        // Recovery overrides the same-cycle shift; lane1 is ignored.
        pred_btb_hit = 2'b11; pred_pc = 32'h0;
        set_upd(0, 32'h20, 4'hA, 2'd1, 1'b1, 1'b1);
        set_upd(1, 32'h24, 4'h0, 2'd0, 1'b1, 1'b0);
        tick(); clear_upd(); pred_req = 1'b0;
        tick();
        pred_req = 1'b1; pred_btb_hit = 2'b00; pred_pc = 32'h30;
        tick();
        check("recovered_ghr", 32'(pred_history_o), 32'h5);
        check("ignored_lane1", 32'(pred_counter_o), 32'hA);
        pred_req = 1'b0;

        // Overflow of the 2-deep queue: one drop on the third cycle.
        set_upd(0, 32'h10, 4'h0, 2'd2, 1'b0, 1'b0); set_upd(1, 32'h14, 4'h0, 2'd2, 1'b0, 1'b0); tick();
        set_upd(0, 32'h18, 4'h0, 2'd2, 1'b0, 1'b0); set_upd(1, 32'h1C, 4'h0, 2'd2, 1'b0, 1'b0); tick();
        set_upd(0, 32'h38, 4'h0, 2'd2, 1'b0, 1'b0); set_upd(1, 32'h3C, 4'h0, 2'd2, 1'b0, 1'b0); tick();
        clear_upd();
        check("overflow_drop", 32'(drop_count_o), 32'd1);
        tick(); tick();
        set_upd(0, 32'h0, 4'h0, 2'd3, 1'b1, 1'b0); set_upd(1, 32'h4, 4'h0, 2'd3, 1'b1, 1'b0);
        tick(); clear_upd();
        check("drained_no_drop", 32'(drop_count_o), 32'd1);
        tick();

        // Same-entry write and read: old value first, new value next access.
        pred_req = 1'b1; pred_btb_hit = 2'b00; pred_pc = 32'h30;
        set_upd(0, 32'h24, 4'h0, 2'd2, 1'b1, 1'b0);
        tick(); clear_upd();
        check("collision_old", 32'(pred_counter_o), 32'hA);
        tick();
        check("collision_new", 32'(pred_counter_o), 32'hB);
        pred_req = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
